vram_port_arbiter: RTL and testbench

- Shares one single-port video RAM between three users:
  - the pixel-fetch path, which is driven by the VGA timing counters;
  - the MCU-side pixel writer;
  - a hardware frame-clear engine.
- Display reads have absolute priority. Writer traffic goes through a small posting FIFO and drains in display-idle cycles.
- The clear engine fills the RAM only during vertical blanking.
- Sits between vga_controller/pixel-fetch logic and the VRAM macro.

---
 rtl/vram_arb_pkg.sv | 29 ++
 rtl/vram_port_arbiter_wr_post_fifo.sv | 70 +++++++
 rtl/vram_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_vram_port_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// Shared types and display-timing defaults for the VRAM port arbiter.
// The V_DISPLAY_* defaults match the vga_controller line numbering.
package vram_arb_pkg;

    localparam int unsigned V_DISPLAY_START_DEF = 35;
    localparam int unsigned V_DISPLAY_END_DEF   = 515;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_e;

    typedef enum logic [1:0] {
        G_NONE,
        G_DISP,
        G_FIFO,
        G_CLEAR
    } grant_e;

    // Lines outside [first_vis, first_blank) are vertical blanking.
    function automatic logic in_vblank(input logic [9:0]  vc,
                                       input int unsigned first_vis,
                                       input int unsigned first_blank);
        logic [31:0] vc_w;
        vc_w = {22'd0, vc};
        return (vc_w < first_vis) || (vc_w >= first_blank);
    endfunction

endpackage

// File: rtl/vram_port_arbiter_wr_post_fifo.sv
// Write-posting FIFO: first-word-fall-through head, simultaneous push/pop allowed.
// Storage has no reset so it can map onto distributed RAM; only pointers reset.
module wr_post_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 23
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned    PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/vram_port_arbiter.sv
// Single-port VRAM arbiter: display reads > posted MCU writes > vblank-only frame clear.
// The RAM port is granted combinationally; only the clear FSM and read-valid are registered.
module vram_port_arbiter
    import vram_arb_pkg::*;
#(
    parameter int unsigned        ADDR_W          = 15,
    parameter int unsigned        DATA_W          = 8,
    parameter int unsigned        FIFO_DEPTH      = 4,
    parameter int unsigned        V_DISPLAY_START = V_DISPLAY_START_DEF,
    parameter int unsigned        V_DISPLAY_END   = V_DISPLAY_END_DEF,
    parameter logic [DATA_W-1:0]  CLEAR_VAL       = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        vcount,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              fifo_empty,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned FW = ADDR_W + DATA_W;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              disp_rvalid_q;
    grant_e            grant;
    logic              vblank;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty_w;
    logic [FW-1:0]     fifo_head;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    assign vblank      = in_vblank(vcount, V_DISPLAY_START, V_DISPLAY_END);
    assign clear_busy  = (state_q == CLEAR);
    assign wr_ready    = !fifo_full && !clear_busy;
    assign fifo_push   = wr_valid && wr_ready;
    assign fifo_pop    = (grant == G_FIFO);
    assign fifo_empty  = fifo_empty_w;
    assign disp_rvalid = disp_rvalid_q;
    assign disp_rdata  = mem_rdata;
    assign {head_addr, head_data} = fifo_head;

    wr_post_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (fifo_push),
        .data_i  ({wr_addr, wr_data}),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty_w)
    );

    // Reset also idles the port so a held disp_req cannot reach the RAM.
    always_comb begin
        grant = G_NONE;
        if (!reset) begin
            if (disp_req) begin
                grant = G_DISP;
            end else if (!fifo_empty_w) begin
                grant = G_FIFO;
            end else if ((state_q == CLEAR) && vblank) begin
                grant = G_CLEAR;
            end
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (grant)
            G_DISP: begin
                mem_en   = 1'b1;
                mem_addr = disp_addr;
            end
            G_FIFO: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = head_addr;
                mem_wdata = head_data;
            end
            G_CLEAR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = clr_addr_q;
                mem_wdata = CLEAR_VAL;
            end
            default: ;
        endcase
    end

    assign clear_done = (grant == G_CLEAR) && (clr_addr_q == '1);

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            IDLE: begin
                if (clear_start) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            CLEAR: begin
                // The counter wraps to 0 on the final write, ready for the next clear.
                if (grant == G_CLEAR) begin
                    clr_addr_d = clr_addr_q + 1'b1;
                    if (clr_addr_q == '1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            clr_addr_q    <= '0;
            disp_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_addr_q    <= clr_addr_d;
            disp_rvalid_q <= disp_req;
        end
    end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench: a default-size instance for read/write-posting checks and a
// 6-bit-address instance (same stimulus, low bits) for full-clear sequences.
module tb_vram_port_arbiter;

    logic        clk;
    logic        reset;
    logic [9:0]  vcount;
    logic        disp_req;
    logic [14:0] disp_addr;
    logic        wr_valid;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;
    logic        clear_start;

    logic [7:0]  b_disp_rdata, b_mem_wdata, b_rdata_r;
    logic        b_disp_rvalid, b_wr_ready, b_clear_busy, b_clear_done, b_fifo_empty;
    logic        b_mem_en, b_mem_we;
    logic [14:0] b_mem_addr;

    logic [7:0]  s_disp_rdata, s_mem_wdata, s_mem_rdata;
    logic        s_disp_rvalid, s_wr_ready, s_clear_busy, s_clear_done, s_fifo_empty;
    logic        s_mem_en, s_mem_we;
    logic [5:0]  s_mem_addr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        req;
        logic [14:0] addr;
        logic        en;
        logic        we;
        logic [14:0] maddr;
        logic [7:0]  wdata;
        logic        rvalid;
        logic        chk_rdata;
        logic [7:0]  rdata;
    } vec_t;

    vec_t vecs [8];

    vram_port_arbiter u_big (
        .clk         (clk),
        .reset       (reset),
        .vcount      (vcount),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_rdata  (b_disp_rdata),
        .disp_rvalid (b_disp_rvalid),
        .wr_valid    (wr_valid),
        .wr_ready    (b_wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .clear_start (clear_start),
        .clear_busy  (b_clear_busy),
        .clear_done  (b_clear_done),
        .fifo_empty  (b_fifo_empty),
        .mem_en      (b_mem_en),
        .mem_we      (b_mem_we),
        .mem_addr    (b_mem_addr),
        .mem_wdata   (b_mem_wdata),
        .mem_rdata   (b_rdata_r)
    );

    vram_port_arbiter #(.ADDR_W(6)) u_small (
        .clk         (clk),
        .reset       (reset),
        .vcount      (vcount),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr[5:0]),
        .disp_rdata  (s_disp_rdata),
        .disp_rvalid (s_disp_rvalid),
        .wr_valid    (wr_valid),
        .wr_ready    (s_wr_ready),
        .wr_addr     (wr_addr[5:0]),
        .wr_data     (wr_data),
        .clear_start (clear_start),
        .clear_busy  (s_clear_busy),
        .clear_done  (s_clear_done),
        .fifo_empty  (s_fifo_empty),
        .mem_en      (s_mem_en),
        .mem_we      (s_mem_we),
        .mem_addr    (s_mem_addr),
        .mem_wdata   (s_mem_wdata),
        .mem_rdata   (s_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-only RAM contents for the big instance; 0x0123 holds 0xA5.
    function automatic logic [7:0] ram_init(input logic [14:0] a);
        if (a == 15'h0123) return 8'hA5;
        return a[7:0] ^ 8'h3C;
    endfunction

    always @(posedge clk) begin
        if (b_mem_en && !b_mem_we) b_rdata_r <= ram_init(b_mem_addr);
    end

    assign s_mem_rdata = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        int cyc;
        int nwr;
        int dones;
        int pause;

        vecs[0] = '{1'b0, 15'h000, 1'b1, 1'b1, 15'h300, 8'h77, 1'b1, 1'b1, 8'h6C};
        vecs[1] = '{1'b1, 15'h010, 1'b1, 1'b0, 15'h010, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[2] = '{1'b0, 15'h000, 1'b1, 1'b1, 15'h301, 8'h78, 1'b1, 1'b1, 8'h2C};
        vecs[3] = '{1'b1, 15'h123, 1'b1, 1'b0, 15'h123, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[4] = '{1'b0, 15'h000, 1'b0, 1'b0, 15'h000, 8'h00, 1'b1, 1'b1, 8'hA5};
        vecs[5] = '{1'b1, 15'h0FF, 1'b1, 1'b0, 15'h0FF, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[6] = '{1'b0, 15'h000, 1'b0, 1'b0, 15'h000, 8'h00, 1'b1, 1'b1, 8'hC3};
        vecs[7] = '{1'b0, 15'h000, 1'b0, 1'b0, 15'h000, 8'h00, 1'b0, 1'b0, 8'h00};

        reset = 1'b1; vcount = 10'd100; disp_req = 1'b0; disp_addr = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0; clear_start = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst disp_rvalid", b_disp_rvalid, 0);
        chk("rst clear_busy", b_clear_busy, 0);
        chk("rst clear_done", b_clear_done, 0);
        chk("rst fifo_empty", b_fifo_empty, 1);
        chk("rst mem_en", b_mem_en, 0);
        chk("rst mem_we", b_mem_we, 0);
        chk("rst mem_addr", b_mem_addr, 0);
        chk("rst mem_wdata", b_mem_wdata, 0);
        reset = 1'b0;

        // Single display read
        @(negedge clk);
        disp_req = 1'b1; disp_addr = 15'h0123;
        #1;
        $display("read: addr=0x%0h", disp_addr);
        chk("rd mem_en", b_mem_en, 1);
        chk("rd mem_we", b_mem_we, 0);
        chk("rd mem_addr", b_mem_addr, 15'h0123);
        @(negedge clk);
        disp_req = 1'b0;
        #1;
        chk("rd rvalid", b_disp_rvalid, 1);
        chk("rd rdata", b_disp_rdata, 8'hA5);

        // Fill FIFO while display holds the port
        @(negedge clk);
        disp_req = 1'b1; disp_addr = 15'h0050;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_addr = 15'h200 + 15'(i); wr_data = 8'h10 + 8'(i);
            #1;
            $display("push %0d: addr=0x%0h data=0x%0h", i, wr_addr, wr_data);
            chk("fill wr_ready", b_wr_ready, 1);
            chk("fill mem_we", b_mem_we, 0);
            @(negedge clk);
        end
        wr_addr = 15'h2FF; wr_data = 8'hEE;
        #1;
        chk("full wr_ready", b_wr_ready, 0);
        chk("full fifo_empty", b_fifo_empty, 0);
        chk("full mem_we", b_mem_we, 0);
        chk("full mem_en", b_mem_en, 1);
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        chk("hold mem_we", b_mem_we, 0);
        @(negedge clk);
        disp_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            $display("drain %0d: addr=0x%0h data=0x%0h", i, b_mem_addr, b_mem_wdata);
            chk("drain mem_en", b_mem_en, 1);
            chk("drain mem_we", b_mem_we, 1);
            chk("drain mem_addr", b_mem_addr, 15'h200 + 15'(i));
            chk("drain mem_wdata", b_mem_wdata, 8'h10 + 8'(i));
            @(negedge clk);
        end
        #1;
        chk("drained fifo_empty", b_fifo_empty, 1);
        chk("drained mem_en", b_mem_en, 0);

        // Queue two writes, then alternate display requests
        @(negedge clk);
        disp_req = 1'b1; disp_addr = 15'h0050;
        wr_valid = 1'b1; wr_addr = 15'h300; wr_data = 8'h77;
        @(negedge clk);
        wr_addr = 15'h301; wr_data = 8'h78;
        @(negedge clk);
        wr_valid = 1'b0;
        for (int v = 0; v < 8; v++) begin
            disp_req = vecs[v].req; disp_addr = vecs[v].addr;
            #1;
            $display("vec %0d: req=%0b addr=0x%0h en=%0b we=%0b maddr=0x%0h rvalid=%0b rdata=0x%0h",
                     v, disp_req, disp_addr, b_mem_en, b_mem_we, b_mem_addr, b_disp_rvalid, b_disp_rdata);
            chk("vec mem_en", b_mem_en, vecs[v].en);
            chk("vec mem_we", b_mem_we, vecs[v].we);
            if (vecs[v].en) chk("vec mem_addr", b_mem_addr, vecs[v].maddr);
            if (vecs[v].we) chk("vec mem_wdata", b_mem_wdata, vecs[v].wdata);
            chk("vec rvalid", b_disp_rvalid, vecs[v].rvalid);
            if (vecs[v].chk_rdata) chk("vec rdata", b_disp_rdata, vecs[v].rdata);
            @(negedge clk);
        end

        // Full clear inside vblank (6-bit instance)
        vcount = 10'd10; clear_start = 1'b1;
        #1;
        chk("clr1 busy before", s_clear_busy, 0);
        chk("clr1 en before", s_mem_en, 0);
        @(negedge clk);
        clear_start = 1'b0;
        #1;
        chk("clr1 busy", s_clear_busy, 1);
        cyc = 0; nwr = 0; dones = 0;
        while (s_clear_busy && cyc < 200) begin
            chk("clr1 write", {s_mem_en, s_mem_we}, 2'b11);
            chk("clr1 addr", s_mem_addr, nwr);
            chk("clr1 wdata", s_mem_wdata, 0);
            chk("clr1 wr_ready", s_wr_ready, 0);
            chk("clr1 done", s_clear_done, (nwr == 63));
            if (s_clear_done) dones++;
            nwr++;
            @(negedge clk);
            #1;
            cyc++;
        end
        $display("clear1: %0d writes, %0d done pulses, %0d cycles", nwr, dones, cyc);
        chk("clr1 bounded", (cyc < 200), 1);
        chk("clr1 writes", nwr, 64);
        chk("clr1 dones", dones, 1);
        chk("clr1 wr_ready after", s_wr_ready, 1);

        // Clear spanning active video: 514 is active, 515 blank, 35 active
        vcount = 10'd514; clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        cyc = 0; nwr = 0; dones = 0; pause = 0;
        while (cyc < 400) begin
            if (cyc < 3) vcount = 10'd514;
            else if (nwr < 20) vcount = 10'd515;
            else if (pause < 10) begin vcount = 10'd35; pause++; end
            else vcount = 10'd0;
            #1;
            if (cyc == 0) chk("clr2 busy", s_clear_busy, 1);
            if (!s_clear_busy) break;
            if (vcount == 10'd514 || vcount == 10'd35) chk("clr2 idle in active", s_mem_en, 0);
            if (s_mem_en && s_mem_we) begin
                if (nwr == 20) $display("clear2: resumed at addr %0d", s_mem_addr);
                chk("clr2 addr", s_mem_addr, nwr);
                if (s_clear_done) dones++;
                nwr++;
            end
            @(negedge clk);
            cyc++;
        end
        $display("clear2: %0d writes, %0d done pulses, %0d paused cycles", nwr, dones, pause);
        chk("clr2 bounded", (cyc < 400), 1);
        chk("clr2 writes", nwr, 64);
        chk("clr2 dones", dones, 1);
        chk("clr2 paused", pause, 10);

        // Reset discards posted writes
        @(negedge clk);
        vcount = 10'd100; disp_req = 1'b1; disp_addr = 15'h0001;
        #1;
        chk("disc wr_ready", s_wr_ready, 1);
        wr_valid = 1'b1; wr_addr = 15'h0005; wr_data = 8'h55;
        @(negedge clk);
        wr_addr = 15'h0006; wr_data = 8'h66;
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        chk("disc fifo_empty pre", s_fifo_empty, 0);
        reset = 1'b1;
        #1;
        $display("reset with 2 posted writes");
        chk("disc fifo_empty", s_fifo_empty, 1);
        chk("disc mem_en", s_mem_en, 0);
        chk("disc rvalid", s_disp_rvalid, 0);
        chk("disc big busy", b_clear_busy, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0; disp_req = 1'b0; vcount = 10'd10;
        nwr = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (s_mem_en) nwr++;
            @(negedge clk);
        end
        chk("disc no writes", nwr, 0);

        // Reset in the middle of a clear
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        #1;
        cyc = 0;
        while (!(s_mem_we && s_mem_addr == 6'd30) && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("mid reached addr 30", (cyc < 100), 1);
        reset = 1'b1;
        #1;
        $display("reset during clear at addr 30");
        chk("mid mem_en", s_mem_en, 0);
        chk("mid mem_we", s_mem_we, 0);
        chk("mid mem_addr", s_mem_addr, 0);
        chk("mid mem_wdata", s_mem_wdata, 0);
        chk("mid clear_busy", s_clear_busy, 0);
        chk("mid clear_done", s_clear_done, 0);
        chk("mid fifo_empty", s_fifo_empty, 1);
        chk("mid rvalid", s_disp_rvalid, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        nwr = 0; dones = 0;
        for (int i = 0; i < 80; i++) begin
            #1;
            if (s_mem_en) nwr++;
            if (s_clear_done) dones++;
            @(negedge clk);
        end
        chk("mid no writes", nwr, 0);
        chk("mid no done", dones, 0);
        chk("mid busy after", s_clear_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
